cordic_phase_prerotate: RTL and testbench

//  NCO front end for the CORDIC oscillator: phase accumulator, quadrant fold
//  and radian conversion producing x0/y0/z0 for stage ITERATION=0 (MODE=0).

---
 rtl/cordic_pkg.sv | 15 +
 rtl/phase_lfsr16.sv | 29 ++
 rtl/cordic_phase_prerotate.sv | 129 ++++++++++++
 tb/tb_cordic_phase_prerotate.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC oscillator front end and its helpers.
package cordic_pkg;

    localparam int CORDIC_FRAC           = 14;
    localparam int CORDIC_INTERNAL_WIDTH = 20;
    localparam int HALF_PI_Q14           = 25736;   // pi/2 in Q2.14
    localparam int INV_GAIN_Q14          = 9949;    // 1/K in Q2.14
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    // Quadrants 1 and 2 lie outside [-pi/2,+pi/2] and must be folded by half a turn.
    function automatic logic needs_fold(input logic [1:0] quadrant);
        return (quadrant == 2'b01) || (quadrant == 2'b10);
    endfunction

endpackage

// File: rtl/phase_lfsr16.sv
// Dither generator: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Only compiled when PHASE_DITHER_EN is defined; otherwise this file is empty.
`ifdef PHASE_DITHER_EN
module phase_lfsr16
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] lfsr
);

    logic feedback_s;

    assign feedback_s = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Shift register: reseed on reset, step once per launched sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (adv) begin
            lfsr <= {lfsr[14:0], feedback_s};
        end else begin
            lfsr <= lfsr;
        end
    end

endmodule
`endif

// File: rtl/cordic_phase_prerotate.sv
// NCO front end for the CORDIC oscillator: phase accumulator, quadrant fold
// into [-pi/2,+pi/2], radian conversion and 1/K pre-scaled seeds x0/y0/z0.
// Optional build macro: PHASE_DITHER_EN adds LFSR dither before truncation.
module cordic_phase_prerotate #(
    parameter int PHASE_W               = 32,
    parameter int CORDIC_INTERNAL_WIDTH = cordic_pkg::CORDIC_INTERNAL_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             sync_clr,
    input  logic                             fcw_wr,
    input  logic [PHASE_W-1:0]               fcw_in,
    input  logic [PHASE_W-1:0]               phase_off,
    output logic [CORDIC_INTERNAL_WIDTH-1:0] x0,
    output logic [CORDIC_INTERNAL_WIDTH-1:0] y0,
    output logic [CORDIC_INTERNAL_WIDTH-1:0] z0,
    output logic                             out_valid
);
    import cordic_pkg::*;

    localparam int CIW = CORDIC_INTERNAL_WIDTH;
    localparam logic signed [31:0]    HALF_PI = 32'(HALF_PI_Q14);
    localparam logic signed [CIW-1:0] X_POS   = CIW'(INV_GAIN_Q14);
    localparam logic signed [CIW-1:0] X_NEG   = -X_POS;

    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] fcw_r;
    logic [PHASE_W-1:0] dither_s;
    logic [15:0]        p_top_s;
    logic               fold_s;
    logic [15:0]        t_next_s;
    logic signed [15:0] t_r;
    logic               neg_r;
    logic               v1_r;
    logic signed [31:0] prod_s;

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr_s;

    phase_lfsr16 u_dither (
        .clk  (clk),
        .rst  (rst),
        .adv  (en),
        .lfsr (lfsr_s)
    );

    assign dither_s = {{(PHASE_W-16){1'b0}}, lfsr_s};
`else
    assign dither_s = {PHASE_W{1'b0}};
`endif

    // Sample phase uses the pre-update accumulator; only the top 16 bits survive truncation.
    assign p_top_s = 16'((acc_r + phase_off + dither_s) >> (PHASE_W - 16));
    assign fold_s  = needs_fold(p_top_s[15:14]);

    // Subtracting half a turn only flips the MSB of the truncated phase.
    always_comb begin
        t_next_s = p_top_s;
        if (fold_s) begin
            t_next_s = {~p_top_s[15], p_top_s[14:0]};
        end else begin
            t_next_s = p_top_s;
        end
    end

    assign prod_s = {{16{t_r[15]}}, t_r} * HALF_PI;

    // Control word register and phase accumulator (sync_clr beats en, wrap is silent).
    always_ff @(posedge clk) begin
        if (rst) begin
            fcw_r <= {PHASE_W{1'b0}};
            acc_r <= {PHASE_W{1'b0}};
        end else begin
            if (fcw_wr) begin
                fcw_r <= fcw_in;
            end else begin
                fcw_r <= fcw_r;
            end
            if (sync_clr) begin
                acc_r <= {PHASE_W{1'b0}};
            end else if (en) begin
                acc_r <= acc_r + fcw_r;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // S1: quadrant fold and truncation to a signed 16-bit half-turn fraction.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_r   <= 16'sd0;
            neg_r <= 1'b0;
            v1_r  <= 1'b0;
        end else begin
            v1_r <= en;
            if (en) begin
                t_r   <= t_next_s;
                neg_r <= fold_s;
            end else begin
                t_r   <= t_r;
                neg_r <= neg_r;
            end
        end
    end

    // S2: scale to radians in Q2.14 and seed x0 with the signed inverse CORDIC gain.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0        <= {CIW{1'b0}};
            y0        <= {CIW{1'b0}};
            z0        <= {CIW{1'b0}};
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1_r;
            if (v1_r) begin
                z0 <= CIW'(prod_s >>> CORDIC_FRAC);
                x0 <= neg_r ? X_NEG : X_POS;
                y0 <= {CIW{1'b0}};
            end else begin
                z0 <= z0;
                x0 <= x0;
                y0 <= y0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_prerotate.sv
// Scoreboard bench for cordic_phase_prerotate (PHASE_W=32, dither disabled).
module tb_cordic_phase_prerotate;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync_clr;
    logic        fcw_wr;
    logic [31:0] fcw_in;
    logic [31:0] phase_off;
    logic [19:0] x0;
    logic [19:0] y0;
    logic [19:0] z0;
    logic        out_valid;

    typedef struct {
        logic [19:0] x;
        logic [19:0] z;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    cordic_phase_prerotate #(.PHASE_W(32), .CORDIC_INTERNAL_WIDTH(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .fcw_wr    (fcw_wr),
        .fcw_in    (fcw_in),
        .phase_off (phase_off),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // One stimulus cycle; a launched sample pushes its hand-computed result.
    task automatic cyc(input logic e, input logic sc, input logic wr, input logic [31:0] f,
                       input logic [31:0] off, input int ex, input int ez);
        exp_t item;
        en = e; sync_clr = sc; fcw_wr = wr; fcw_in = f; phase_off = off;
        if (e) begin
            item.x = ex[19:0];
            item.z = ez[19:0];
            sb_q.push_back(item);
        end
        @(negedge clk);
    endtask

    // Monitor: compare every presented sample against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: out_valid=1 x0=%0d z0=%0d expected no sample",
                         $signed(x0), $signed(z0));
            end else begin
                e = sb_q.pop_front();
                if (x0 !== e.x || z0 !== e.z || y0 !== 20'd0) begin
                    errors++;
                    $display("FAIL sample: got x0=%0d y0=%0d z0=%0d expected x0=%0d y0=0 z0=%0d",
                             $signed(x0), $signed(y0), $signed(z0), $signed(e.x), $signed(e.z));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; sync_clr = 1'b0; fcw_wr = 1'b0;
        fcw_in = 32'd0; phase_off = 32'd0;

        // Reset held 3 cycles with en high: outputs stay zero.
        repeat (3) begin
            @(negedge clk);
            chk("reset_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_xyz", {12'd0, x0 | y0 | z0}, 32'd0);
        end
        rst = 1'b0; en = 1'b0;
        @(negedge clk);

        // Quarter-turn steps walk the four quadrants, then repeat.
        cyc(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'd0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  9949,      0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -9949, -25736);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -9949,      0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  9949, -25736);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  9949,      0);

        // Static offsets with a frozen accumulator.
        cyc(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'h2000_0000,  9949,  12868);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'h2000_0000,  9949,  12868);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'h6000_0000, -9949, -12868);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'hC000_0000,  9949, -25736);

        // fcw write alongside en: that step uses the old word.
        cyc(1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'd0, 9949,    0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0,         32'd0, 9949,    0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0,         32'd0, 9949, 6434);

        // sync_clr with en: sample sees old acc, next sample sees zero.
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 9949, 12868);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 9949,     0);

        // Accumulator wrap: 0xF000_0000 + 0x2000_0000 -> 0x1000_0000.
        cyc(1'b0, 1'b1, 1'b1, 32'hF000_0000, 32'd0, 0, 0);
        cyc(1'b1, 1'b0, 1'b1, 32'h2000_0000, 32'd0, 9949,     0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0,         32'd0, 9949, -6434);
        cyc(1'b1, 1'b0, 1'b0, 32'd0,         32'd0, 9949,  6434);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);

        // Single en pulse: out_valid exactly two cycles later, one cycle wide; data holds.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 9949, 19302);
        chk("lat_n1", {31'd0, out_valid}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk("lat_n2", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("lat_n3", {31'd0, out_valid}, 32'd0);
        chk("hold_z0", {{12{z0[19]}}, z0}, 32'd19302);

        // Reset between en and out_valid drops the in-flight sample.
        en = 1'b1;
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_z0", {12'd0, z0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_after", {31'd0, out_valid}, 32'd0);

        // After reset fcw and acc are zero again.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 9949, 0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 9949, 0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
